mdio_master: RTL and testbench

//  Parametrised IEEE 802.3 Clause-22 MDIO management master; successor to the fixed 32-bit serialiser.

---
 rtl/mdio_pkg.sv | 27 ++
 rtl/mdio_clk_gen.sv | 46 ++++
 rtl/mdio_master.sv | 200 ++++++++++++++++++++
 tb/tb_mdio_master.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared types and constants for the Clause-22 MDIO master.
//   state_t   frame sequencing states (IDLE, PRE, ST, OPC, PHY, REG, TA, DATA)
//   OP_WR/OP_RD  opcode field values; ST_C22 start pattern; TA_WR write turnaround
//   op_valid()   true for the two opcodes the master will accept
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ST,
    OPC,
    PHY,
    REG,
    TA,
    DATA
  } state_t;

  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] TA_WR  = 2'b10;

  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_WR) || (op == OP_RD);
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen: MDC generator. A down-counter runs only while en=1 and
// splits each bit period into a low half followed by a high half.
//   clk, RESET  system clock, synchronous active-high reset
//   en          transaction active; counter parks at its top value otherwise
//   mdc         registered management clock (0 while idle)
//   fall_stb    high in the last clk cycle of a bit period (next bit starts)
//   rise_stb    high in the clk cycle whose closing edge raises MDC
module mdio_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic RESET,
  input  logic en,
  output logic mdc,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] CNT_TOP  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] CNT_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;

  // Counter value CNT_TOP marks the first (low) cycle of a bit period, so
  // the period always starts with MDC low, including the first bit.
  always_comb begin
    cnt_nxt = CNT_TOP;
    if (en && (cnt != '0)) cnt_nxt = cnt - DIV_W'(1);
  end

  assign fall_stb = en && (cnt == '0);
  assign rise_stb = en && (cnt == CNT_HALF);

  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt <= CNT_TOP;
      mdc <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      mdc <= (cnt_nxt < CNT_HALF);
    end
  end

endmodule

// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause-22 MDIO management master.
// Frame (MSB first): PRE_LEN ones, ST, OP, PHY_ADR, REG_ADR, TA, DATA.
//   clk, RESET   system clock, synchronous active-high reset
//   MDIO_START   request, taken only while BUSY=0 and OP is write/read
//   OP           2'b01 write, 2'b10 read
//   PHY_ADR, REG_ADR, WR_DATA   frame fields, latched at accept
//   MDIO_IN      pad input, sampled on the clk edge that raises MDC
//   MDC, MDIO_OUT, MDIO_OE      pad side (tristate built by the parent)
//   BUSY         transaction in progress
//   DATA_RDY     one-cycle pulse after the last bit of every transaction
//   RD_DATA      last read result, updated only when a read completes
//   RD_ERR       present only with `define MDIO_RD_ERR_EN: second read TA
//                bit seen high (no PHY answering)
//
// state | meaning
// IDLE  | waiting for a request, MDC held low, pad released
// PRE   | preamble ones (skipped when PRE_LEN=0)
// ST    | start pattern 01
// OPC   | opcode
// PHY   | PHY address
// REG   | register address
// TA    | turnaround: write drives 10, read releases the pad
// DATA  | payload: write drives WR_DATA, read shifts MDIO_IN
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int PRE_LEN = 32,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              MDIO_START,
  input  logic [1:0]        OP,
  input  logic [4:0]        PHY_ADR,
  input  logic [4:0]        REG_ADR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              MDIO_IN,
  output logic              MDC,
  output logic              MDIO_OUT,
  output logic              MDIO_OE,
  output logic              BUSY,
  output logic              DATA_RDY,
  output logic [DATA_W-1:0] RD_DATA
`ifdef MDIO_RD_ERR_EN
  ,
  output logic              RD_ERR
`endif
);

  localparam int CNT_MAX = (PRE_LEN > DATA_W) ? ((PRE_LEN > 5) ? PRE_LEN : 5)
                                              : ((DATA_W > 5) ? DATA_W : 5);
  localparam int CNT_W  = $clog2(CNT_MAX);
  localparam int DIDX_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] LEN_PRE  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] LEN_2    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LEN_5    = CNT_W'(4);
  localparam logic [CNT_W-1:0] LEN_DATA = CNT_W'(DATA_W - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bcnt, bcnt_nxt;
  logic               accept, done;
  logic               out_nxt, oe_nxt;
  logic               fall_stb, rise_stb;
  logic               is_wr;
  logic [1:0]         op_q;
  logic [4:0]         phy_q, reg_q;
  logic [DATA_W-1:0]  wr_q, rx_sr;
`ifdef MDIO_RD_ERR_EN
  logic               ta_err;
`endif

  assign BUSY  = (state != IDLE);
  assign is_wr = (op_q == OP_WR);

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .RESET    (RESET),
    .en       (BUSY),
    .mdc      (MDC),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= IDLE;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    accept    = 1'b0;
    done      = 1'b0;
    out_nxt   = 1'b0;
    oe_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (MDIO_START && op_valid(OP)) begin
          accept = 1'b1;
          if (PRE_LEN > 0) begin
            state_nxt = PRE;
            bcnt_nxt  = LEN_PRE;
          end else begin
            state_nxt = ST;
            bcnt_nxt  = LEN_2;
          end
        end
      end
      default: begin
        if (fall_stb) begin
          if (bcnt != '0) begin
            bcnt_nxt = bcnt - CNT_W'(1);
          end else begin
            case (state)
              PRE:     begin state_nxt = ST;   bcnt_nxt = LEN_2;    end
              ST:      begin state_nxt = OPC;  bcnt_nxt = LEN_2;    end
              OPC:     begin state_nxt = PHY;  bcnt_nxt = LEN_5;    end
              PHY:     begin state_nxt = REG;  bcnt_nxt = LEN_5;    end
              REG:     begin state_nxt = TA;   bcnt_nxt = LEN_2;    end
              TA:      begin state_nxt = DATA; bcnt_nxt = LEN_DATA; end
              default: begin state_nxt = IDLE; bcnt_nxt = '0; done = 1'b1; end
            endcase
          end
        end
      end
    endcase

    // Pad values are computed for the upcoming cycle and registered, so the
    // pad only changes at bit-period starts. At accept the target state is
    // PRE or ST, which need only constants, so unlatched fields are never used.
    case (state_nxt)
      PRE: begin out_nxt = 1'b1;                            oe_nxt = 1'b1;  end
      ST:  begin out_nxt = ST_C22[bcnt_nxt[0]];             oe_nxt = 1'b1;  end
      OPC: begin out_nxt = op_q[bcnt_nxt[0]];               oe_nxt = 1'b1;  end
      PHY: begin out_nxt = phy_q[bcnt_nxt[2:0]];            oe_nxt = 1'b1;  end
      REG: begin out_nxt = reg_q[bcnt_nxt[2:0]];            oe_nxt = 1'b1;  end
      TA:  begin out_nxt = is_wr & TA_WR[bcnt_nxt[0]];      oe_nxt = is_wr; end
      DATA: begin
        out_nxt = is_wr & wr_q[bcnt_nxt[DIDX_W-1:0]];
        oe_nxt  = is_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      MDIO_OUT <= 1'b0;
      MDIO_OE  <= 1'b0;
      DATA_RDY <= 1'b0;
      RD_DATA  <= '0;
      op_q     <= '0;
      phy_q    <= '0;
      reg_q    <= '0;
      wr_q     <= '0;
      rx_sr    <= '0;
`ifdef MDIO_RD_ERR_EN
      ta_err   <= 1'b0;
      RD_ERR   <= 1'b0;
`endif
    end else begin
      MDIO_OUT <= out_nxt;
      MDIO_OE  <= oe_nxt;
      DATA_RDY <= done;
      if (accept) begin
        op_q  <= OP;
        phy_q <= PHY_ADR;
        reg_q <= REG_ADR;
        wr_q  <= WR_DATA;
`ifdef MDIO_RD_ERR_EN
        ta_err <= 1'b0;
        RD_ERR <= 1'b0;
`endif
      end
      if (rise_stb && !is_wr) begin
        if (state == DATA) rx_sr <= {rx_sr[DATA_W-2:0], MDIO_IN};
`ifdef MDIO_RD_ERR_EN
        // A present PHY pulls the second TA bit low.
        if ((state == TA) && (bcnt == '0)) ta_err <= MDIO_IN;
`endif
      end
      // The last data bit was already shifted in at its MDC rise.
      if (done && !is_wr) begin
        RD_DATA <= rx_sr;
`ifdef MDIO_RD_ERR_EN
        RD_ERR  <= ta_err;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
module tb_mdio_master;

  localparam int D = 4;
  localparam int P = 32;
  localparam int W = 16;
  localparam int N = P + 16 + W;

  logic         clk = 1'b0;
  logic         RESET;
  logic         MDIO_START;
  logic [1:0]   OP;
  logic [4:0]   PHY_ADR;
  logic [4:0]   REG_ADR;
  logic [W-1:0] WR_DATA;
  logic         MDIO_IN;
  logic         MDC;
  logic         MDIO_OUT;
  logic         MDIO_OE;
  logic         BUSY;
  logic         DATA_RDY;
  logic [W-1:0] RD_DATA;
`ifdef MDIO_RD_ERR_EN
  logic         RD_ERR;
`endif

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] rd_model;
  logic         err_model;
  logic [N-1:0] last_frame;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(D), .PRE_LEN(P), .DATA_W(W)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .MDIO_START (MDIO_START),
    .OP         (OP),
    .PHY_ADR    (PHY_ADR),
    .REG_ADR    (REG_ADR),
    .WR_DATA    (WR_DATA),
    .MDIO_IN    (MDIO_IN),
    .MDC        (MDC),
    .MDIO_OUT   (MDIO_OUT),
    .MDIO_OE    (MDIO_OE),
    .BUSY       (BUSY),
    .DATA_RDY   (DATA_RDY),
    .RD_DATA    (RD_DATA)
`ifdef MDIO_RD_ERR_EN
    ,
    .RD_ERR     (RD_ERR)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mdc"}, 64'(MDC), 64'(0));
    chk({tag, "_out"}, 64'(MDIO_OUT), 64'(0));
    chk({tag, "_oe"}, 64'(MDIO_OE), 64'(0));
    chk({tag, "_busy"}, 64'(BUSY), 64'(0));
    chk({tag, "_rdy"}, 64'(DATA_RDY), 64'(0));
    chk({tag, "_rd_data"}, 64'(RD_DATA), 64'(0));
`ifdef MDIO_RD_ERR_EN
    chk({tag, "_rd_err"}, 64'(RD_ERR), 64'(0));
`endif
  endtask

  // Called at a falling edge with the bus idle (or in a DATA_RDY cycle);
  // returns at the falling edge inside the DATA_RDY cycle of this frame.
  task automatic run_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                           input logic [W-1:0] wd, input logic [W-1:0] resp,
                           input bit absent, input bit hold, input int pulse_j);
    logic [N-1:0] exp_f, obs_f, mask;
    bit           is_wr;
    int           b, ph, mdc_e, oe_e, busy_e, rdy_e, stab_e, rd_e;
    is_wr  = (op == 2'b01);
    exp_f  = {{P{1'b1}}, 2'b01, op, phy, ra, is_wr ? 2'b10 : 2'b00, is_wr ? wd : {W{1'b0}}};
    mask   = is_wr ? {N{1'b1}} : ({N{1'b1}} << (W + 2));
    obs_f  = '0;
    mdc_e = 0; oe_e = 0; busy_e = 0; rdy_e = 0; stab_e = 0; rd_e = 0;
    OP = op; PHY_ADR = phy; REG_ADR = ra; WR_DATA = wd;
    MDIO_START = 1'b1;
    for (int j = 1; j <= N * D; j++) begin
      @(negedge clk);
      b  = (j - 1) / D;
      ph = (j - 1) % D;
      if (j == 1 && !hold) MDIO_START = 1'b0;
      if (pulse_j > 1 && j == pulse_j) begin
        MDIO_START = 1'b1;
        OP = 2'($urandom); PHY_ADR = 5'($urandom); REG_ADR = 5'($urandom); WR_DATA = W'($urandom);
      end else if (pulse_j > 1 && j == pulse_j + 1) begin
        MDIO_START = hold;
      end
      if (is_wr || absent) MDIO_IN = 1'b1;
      else if (b == P + 15) MDIO_IN = 1'b0;
      else if (b >= P + 16) MDIO_IN = resp[N - 1 - b];
      else MDIO_IN = 1'b1;
      if (MDC !== (ph >= D / 2)) mdc_e++;
      if (MDIO_OE !== mask[N - 1 - b]) oe_e++;
      if (BUSY !== 1'b1) busy_e++;
      if (DATA_RDY !== 1'b0) rdy_e++;
      if (RD_DATA !== rd_model) rd_e++;
      if (ph == 0) obs_f[N - 1 - b] = MDIO_OUT;
      else if (MDIO_OUT !== obs_f[N - 1 - b]) stab_e++;
    end
    @(negedge clk);
    MDIO_IN = 1'b1;
    if (!is_wr) rd_model = absent ? {W{1'b1}} : resp;
    err_model  = !is_wr && absent;
    last_frame = obs_f;
    chk("frame_bits", 64'(obs_f & mask), 64'(exp_f & mask));
    chk("mdc_shape", 64'(mdc_e), 64'(0));
    chk("oe_shape", 64'(oe_e), 64'(0));
    chk("busy_in_frame", 64'(busy_e), 64'(0));
    chk("early_rdy", 64'(rdy_e), 64'(0));
    chk("out_stable", 64'(stab_e), 64'(0));
    chk("rd_data_held", 64'(rd_e), 64'(0));
    chk("end_rdy", 64'(DATA_RDY), 64'(1));
    chk("end_busy", 64'(BUSY), 64'(0));
    chk("end_mdc", 64'(MDC), 64'(0));
    chk("end_oe", 64'(MDIO_OE), 64'(0));
    chk("end_rd_data", 64'(RD_DATA), 64'(rd_model));
`ifdef MDIO_RD_ERR_EN
    chk("end_rd_err", 64'(RD_ERR), 64'(err_model));
`endif
  endtask

  task automatic idle_cycles(input int n);
    int e;
    e = 0;
    MDIO_START = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (BUSY !== 1'b0 || MDC !== 1'b0 || MDIO_OE !== 1'b0 ||
          MDIO_OUT !== 1'b0 || DATA_RDY !== 1'b0) e++;
    end
    if (n > 0) chk("idle_quiet", 64'(e), 64'(0));
  endtask

  initial begin
    logic [1:0] rop;
    bit         rhold;
    RESET = 1'b1; MDIO_START = 1'b0; OP = 2'b00; PHY_ADR = '0; REG_ADR = '0;
    WR_DATA = '0; MDIO_IN = 1'b1; rd_model = '0; err_model = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    RESET = 1'b0;
    idle_cycles(2);

    run_frame(2'b01, 5'd1, 5'd2, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 0);
    chk("wr_preamble", 64'(last_frame[N-1:N-32]), 64'(32'hFFFF_FFFF));
    chk("wr_fields", 64'(last_frame[31:0]), 64'(32'h508A_BEEF));
    idle_cycles(3);

    run_frame(2'b10, 5'd1, 5'd2, 16'h0000, 16'h1234, 1'b0, 1'b0, 0);
    chk("rd_header", 64'(last_frame[31:18]), 64'(14'b01_10_00001_00010));
    chk("rd_value", 64'(RD_DATA), 64'(16'h1234));
    idle_cycles(2);

    // Invalid opcodes must not start anything.
    OP = 2'b11; MDIO_START = 1'b1;
    @(negedge clk);
    chk("bad_op11_busy", 64'(BUSY), 64'(0));
    OP = 2'b00;
    @(negedge clk);
    chk("bad_op00_busy", 64'(BUSY), 64'(0));
    idle_cycles(4);

    // Start pulses with scrambled fields while busy must not alter the frame.
    run_frame(2'b01, 5'd9, 5'd17, 16'h1357, 16'h0000, 1'b0, 1'b0, 100);
    run_frame(2'b10, 5'd30, 5'd5, 16'h0000, 16'hC3A5, 1'b0, 1'b0, 150);
    idle_cycles(1);

    // Reset in bit 40 of a write aborts at once with no DATA_RDY.
    OP = 2'b01; PHY_ADR = 5'd3; REG_ADR = 5'd4; WR_DATA = 16'hA5A5; MDIO_START = 1'b1;
    for (int j = 1; j <= 40 * D + 1; j++) begin
      @(negedge clk);
      if (j == 1) MDIO_START = 1'b0;
    end
    RESET = 1'b1;
    rd_model = '0; err_model = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    RESET = 1'b0;
    idle_cycles(N * D);
    run_frame(2'b01, 5'd3, 5'd4, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 0);

    // MDIO_START held high: frames follow each other after one idle cycle.
    run_frame(2'b01, 5'd7, 5'd8, 16'h0F0F, 16'h0000, 1'b0, 1'b1, 0);
    run_frame(2'b10, 5'd7, 5'd8, 16'h0000, 16'h8001, 1'b0, 1'b1, 0);
    run_frame(2'b01, 5'd7, 5'd9, 16'hF00D, 16'h0000, 1'b0, 1'b0, 0);
    idle_cycles(2);

    // No PHY answering, then a good read.
    run_frame(2'b10, 5'd31, 5'd1, 16'h0000, 16'h5555, 1'b1, 1'b0, 0);
    chk("absent_rd_data", 64'(RD_DATA), 64'(16'hFFFF));
    run_frame(2'b10, 5'd1, 5'd1, 16'h0000, 16'h2468, 1'b0, 1'b0, 0);
    idle_cycles(1);

    for (int it = 0; it < 12; it++) begin
      rop   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      rhold = ($urandom_range(0, 3) == 0);
      run_frame(rop, 5'($urandom), 5'($urandom), W'($urandom), W'($urandom),
                ($urandom_range(0, 3) == 0),
                rhold,
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, N * D - 1)));
      if (!rhold) idle_cycles(int'($urandom_range(0, 3)));
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
